// File: rtl/button_input_port.sv
// button_input_port: input-side system register for the board push-button.
// Synchronises and debounces the raw pin, latches press/release/overrun
// events, counts presses and exposes status or count on the shared CPU bus.
module button_input_port #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn,
  input  logic [1:0] i_read,
  inout  wire [23:0] io_bus,
  output logic       o_pressed,
  output logic       o_irq
);

  // Terminal value of the debounce counter; reaching it with the level still
  // different from the accepted one commits the new level.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_stable;
  logic [15:0] r_debCnt;
  logic        r_pressFlag;
  logic        r_releaseFlag;
  logic        r_overrunFlag;
  logic [7:0]  r_count;

  logic        w_btnNorm;
  logic        w_differs;
  logic        w_accept;
  logic        w_rise;
  logic        w_fall;
  logic        w_clear;
  logic [7:0]  w_status;
  logic [7:0]  w_readByte;

  // Normalise polarity so that 1 always means "pressed" downstream.
  assign w_btnNorm = ACTIVE_LOW ? ~i_btn : i_btn;

  assign w_differs = (r_sync2 != r_stable);
  assign w_accept  = w_differs && (r_debCnt == CNT_LAST);
  assign w_rise    = w_accept && r_sync2;
  assign w_fall    = w_accept && !r_sync2;
  assign w_clear   = (i_read == 2'b11);

  // Two-stage synchroniser; reset loads the released level.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_btnNorm;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: a new level must persist DEBOUNCE_CYCLES cycles to be accepted.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stable <= 1'b0;
      r_debCnt <= 16'd0;
    end else if (!w_differs) begin
      r_debCnt <= 16'd0;
    end else if (w_accept) begin
      r_stable <= r_sync2;
      r_debCnt <= 16'd0;
    end else begin
      r_debCnt <= r_debCnt + 16'd1;
    end
  end

  // Sticky event flags; a new event wins over a simultaneous clear, and the
  // overrun flag is always cleared by a clear.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pressFlag   <= 1'b0;
      r_releaseFlag <= 1'b0;
      r_overrunFlag <= 1'b0;
    end else begin
      r_pressFlag   <= w_rise || (r_pressFlag && !w_clear);
      r_releaseFlag <= w_fall || (r_releaseFlag && !w_clear);
      if (w_clear) begin
        r_overrunFlag <= 1'b0;
      end else if (w_rise && r_pressFlag) begin
        r_overrunFlag <= 1'b1;
      end
    end
  end

  // Press counter, 8-bit wrapping, untouched by the flag clear.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= 8'd0;
    end else if (w_rise) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign w_status = {4'h0, r_overrunFlag, r_releaseFlag, r_pressFlag, r_stable};

  // Select the byte presented on the bus for the current read strobe.
  always_comb begin
    w_readByte = w_status;
    if (i_read == 2'b10) begin
      w_readByte = r_count;
    end
  end

  assign io_bus    = (i_read != 2'b00) ? {16'h0000, w_readByte} : 24'hzzzzzz;
  assign o_pressed = r_stable;
  assign o_irq     = r_pressFlag;

endmodule

// File: tb/tb_button_input_port.sv
// Directed testbench for button_input_port (DEBOUNCE_CYCLES=16, ACTIVE_LOW=1).
module tb_button_input_port;

  logic        i_clk;
  logic        i_reset;
  logic        i_btn;
  logic [1:0]  i_read;
  wire  [23:0] w_bus;
  logic        o_pressed;
  logic        o_irq;

  int passCount;
  int totalCount;

  button_input_port #(
    .DEBOUNCE_CYCLES(16),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_btn(i_btn),
    .i_read(i_read),
    .io_bus(w_bus),
    .o_pressed(o_pressed),
    .o_irq(o_irq)
  );

  // Free-running 10 ns clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hold reset for a few cycles with the pin released, then release on a negedge.
  task doReset();
    i_reset = 1'b0;
    i_btn   = 1'b1;
    i_read  = 2'b00;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  // Change the pin just after a rising edge.
  task setPin(input logic v);
    @(posedge i_clk);
    #1 i_btn = v;
  endtask

  task waitEdges(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task test_reset();
    doReset();
    #1;
    totalCount++;
    if (o_pressed !== 1'b0) $display("[TB] FAIL reset_pressed: got %b expected 0", o_pressed);
    else passCount++;
    totalCount++;
    if (o_irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", o_irq);
    else passCount++;
    i_read = 2'b01; #1;
    totalCount++;
    if (w_bus !== 24'h000000) $display("[TB] FAIL reset_status: got %h expected 000000", w_bus);
    else passCount++;
    i_read = 2'b10; #1;
    totalCount++;
    if (w_bus !== 24'h000000) $display("[TB] FAIL reset_count: got %h expected 000000", w_bus);
    else passCount++;
    i_read = 2'b00;
  endtask

  task test_press_latency();
    doReset();
    setPin(1'b0);
    waitEdges(17);
    totalCount++;
    if (o_pressed !== 1'b0) $display("[TB] FAIL latency_early: got %b expected 0", o_pressed);
    else passCount++;
    waitEdges(1);
    totalCount++;
    if (o_pressed !== 1'b1) $display("[TB] FAIL latency_exact: got %b expected 1", o_pressed);
    else passCount++;
    totalCount++;
    if (o_irq !== 1'b1) $display("[TB] FAIL press_irq: got %b expected 1", o_irq);
    else passCount++;
    i_read = 2'b01; #1;
    totalCount++;
    if (w_bus !== 24'h000003) $display("[TB] FAIL press_status: got %h expected 000003", w_bus);
    else passCount++;
    i_read = 2'b10; #1;
    totalCount++;
    if (w_bus !== 24'h000001) $display("[TB] FAIL press_count: got %h expected 000001", w_bus);
    else passCount++;
    i_read = 2'b00;
  endtask

  task test_glitch();
    doReset();
    setPin(1'b0);
    waitEdges(9);
    setPin(1'b1);
    waitEdges(30);
    totalCount++;
    if (o_pressed !== 1'b0) $display("[TB] FAIL glitch_pressed: got %b expected 0", o_pressed);
    else passCount++;
    i_read = 2'b01; #1;
    totalCount++;
    if (w_bus !== 24'h000000) $display("[TB] FAIL glitch_status: got %h expected 000000", w_bus);
    else passCount++;
    i_read = 2'b10; #1;
    totalCount++;
    if (w_bus !== 24'h000000) $display("[TB] FAIL glitch_count: got %h expected 000000", w_bus);
    else passCount++;
    i_read = 2'b00;
  endtask

  task test_overrun();
    doReset();
    setPin(1'b0); waitEdges(20);
    setPin(1'b1); waitEdges(20);
    setPin(1'b0); waitEdges(20);
    i_read = 2'b01; #1;
    totalCount++;
    if (w_bus !== 24'h00000F) $display("[TB] FAIL overrun_status: got %h expected 00000F", w_bus);
    else passCount++;
    i_read = 2'b10; #1;
    totalCount++;
    if (w_bus !== 24'h000002) $display("[TB] FAIL overrun_count: got %h expected 000002", w_bus);
    else passCount++;
    i_read = 2'b00;
  endtask

  task test_clear_vs_event();
    doReset();
    setPin(1'b0); waitEdges(20);
    setPin(1'b1); waitEdges(20);
    i_read = 2'b01; #1;
    totalCount++;
    if (w_bus !== 24'h000006) $display("[TB] FAIL preclear_status: got %h expected 000006", w_bus);
    else passCount++;
    i_read = 2'b00;
    setPin(1'b0);
    waitEdges(17);
    i_read = 2'b11; #1;
    totalCount++;
    if (w_bus !== 24'h000006) $display("[TB] FAIL clear_read_value: got %h expected 000006", w_bus);
    else passCount++;
    waitEdges(1);
    i_read = 2'b01; #1;
    totalCount++;
    if (w_bus !== 24'h000003) $display("[TB] FAIL clear_event_wins: got %h expected 000003", w_bus);
    else passCount++;
    i_read = 2'b10; #1;
    totalCount++;
    if (w_bus !== 24'h000002) $display("[TB] FAIL clear_keeps_count: got %h expected 000002", w_bus);
    else passCount++;
    i_read = 2'b00;
    waitEdges(2);
    i_read = 2'b11;
    waitEdges(1);
    i_read = 2'b01; #1;
    totalCount++;
    if (w_bus !== 24'h000001) $display("[TB] FAIL plain_clear: got %h expected 000001", w_bus);
    else passCount++;
    i_read = 2'b00;
  endtask

  task test_wrap_and_reset();
    doReset();
    for (int i = 0; i < 255; i++) begin
      setPin(1'b0); waitEdges(19);
      setPin(1'b1); waitEdges(19);
    end
    i_read = 2'b10; #1;
    totalCount++;
    if (w_bus !== 24'h0000FF) $display("[TB] FAIL count_255: got %h expected 0000FF", w_bus);
    else passCount++;
    i_read = 2'b00;
    setPin(1'b0); waitEdges(19);
    setPin(1'b1); waitEdges(19);
    i_read = 2'b10; #1;
    totalCount++;
    if (w_bus !== 24'h000000) $display("[TB] FAIL count_wrap: got %h expected 000000", w_bus);
    else passCount++;
    i_read = 2'b01; #1;
    totalCount++;
    if (w_bus !== 24'h00000E) $display("[TB] FAIL wrap_status: got %h expected 00000E", w_bus);
    else passCount++;
    i_read = 2'b00;
    setPin(1'b0);
    waitEdges(10);
    i_reset = 1'b0;
    #1;
    totalCount++;
    if (o_irq !== 1'b0) $display("[TB] FAIL midreset_irq: got %b expected 0", o_irq);
    else passCount++;
    i_read = 2'b01; #1;
    totalCount++;
    if (w_bus !== 24'h000000) $display("[TB] FAIL midreset_status: got %h expected 000000", w_bus);
    else passCount++;
    i_read = 2'b10; #1;
    totalCount++;
    if (w_bus !== 24'h000000) $display("[TB] FAIL midreset_count: got %h expected 000000", w_bus);
    else passCount++;
    i_read = 2'b00;
    @(negedge i_clk);
    i_reset = 1'b1;
    waitEdges(17);
    totalCount++;
    if (o_pressed !== 1'b0) $display("[TB] FAIL postreset_early: got %b expected 0", o_pressed);
    else passCount++;
    waitEdges(1);
    totalCount++;
    if (o_pressed !== 1'b1) $display("[TB] FAIL postreset_full_latency: got %b expected 1", o_pressed);
    else passCount++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    passCount  = 0;
    totalCount = 0;
    i_reset    = 1'b0;
    i_btn      = 1'b1;
    i_read     = 2'b00;
    test_reset();
    test_press_latency();
    test_glitch();
    test_overrun();
    test_clear_vs_event();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
